// File: rtl/rate_select.sv
// -----------------------------------------------------------------------------
// rate_select
//   Turns raw pushbuttons and slide switches into a blink-rate selection.
//   Every raw input is synchronized and then debounced with its own counter.
//   The highest debounced switch that is on selects the rate. With all switches
//   off, a manual index is used instead: KEY[0] loads 4, KEY[1] steps up and
//   KEY[2] steps down. KEY[3] toggles PAUSE.
//
// Ports
//   CLOCK_50    in   1  only clock, rising edge
//   RESET       in   1  synchronous, active-high
//   KEY         in   4  raw active-low pushbuttons (0 = pressed)
//   SW          in  10  raw slide switches (1 = on)
//   HALF_PERIOD out 28  CLOCK_50 cycles between blinker toggles (registered)
//   RATE_IDX    out  4  rate table index driving HALF_PERIOD (registered)
//   RATE_STB    out  1  one-cycle pulse when RATE_IDX/HALF_PERIOD change
//   PAUSE       out  1  hold request to the blinker
//   KEY_PRESS   out  4  one-cycle pulse per debounced key press
// -----------------------------------------------------------------------------
module rate_select #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [27:0] HALF_PERIOD,
  output logic [3:0]  RATE_IDX,
  output logic        RATE_STB,
  output logic        PAUSE,
  output logic [3:0]  KEY_PRESS
);

  localparam int NIN = 14;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  // Input vector is {SW, KEY}. Keys idle high, switches idle low.
  localparam logic [NIN-1:0] IN_RST   = {10'b00_0000_0000, 4'b1111};
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  function automatic logic [27:0] rate_lookup(input logic [3:0] idx);
    logic [27:0] hp;
    case (idx)
      4'd0:    hp = 28'd200000000;
      4'd1:    hp = 28'd150000000;
      4'd2:    hp = 28'd100000000;
      4'd3:    hp = 28'd75000000;
      4'd4:    hp = 28'd50000000;
      4'd5:    hp = 28'd37500000;
      4'd6:    hp = 28'd25000000;
      4'd7:    hp = 28'd12500000;
      4'd8:    hp = 28'd6250000;
      4'd9:    hp = 28'd3125000;
      default: hp = 28'd50000000;
    endcase
    return hp;
  endfunction

  logic [NIN-1:0] sync_q [SYNC_STAGES];
  logic [NIN-1:0] sync_s;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];
  logic [NIN-1:0] deb_q, deb_d;
  logic [3:0]     key_prev_q;
  logic [3:0]     press_q, press_d;
  logic [3:0]     man_q, man_d;
  logic [3:0]     eff_s;
  logic [3:0]     idx_q;
  logic [27:0]    hp_q;
  logic           stb_q;
  logic           pause_q, pause_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain for all raw inputs
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RST;
    end else begin
      sync_q[0] <= {SW, KEY};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Debounce: count consecutive mismatching cycles; accept on the Nth
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_s[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce counters and debounced levels
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      deb_q <= IN_RST;
    end else begin
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      deb_q <= deb_d;
    end
  end

  // Press edge (debounced 1->0), manual index and pause next-state
  always_comb begin
    press_d = key_prev_q & ~deb_q[3:0];
    pause_d = pause_q ^ press_q[3];
    man_d   = man_q;
    if (press_q[0]) begin
      man_d = 4'd4;
    end else if (press_q[1] && press_q[2]) begin
      man_d = man_q;   // up and down together cancel
    end else if (press_q[1]) begin
      if (man_q < 4'd9) man_d = man_q + 4'd1;
      else              man_d = man_q;
    end else if (press_q[2]) begin
      if (man_q > 4'd0) man_d = man_q - 4'd1;
      else              man_d = man_q;
    end else begin
      man_d = man_q;
    end
  end

  // Effective index: highest debounced switch on, else the manual index
  always_comb begin
    eff_s = man_q;
    for (int b = 0; b < 10; b++) begin
      if (deb_q[4+b]) eff_s = 4'(b);
      else            eff_s = eff_s;
    end
  end

  // Key edge history, manual index, pause and rate outputs
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_prev_q <= 4'b1111;
      press_q    <= 4'b0000;
      man_q      <= 4'd4;
      pause_q    <= 1'b0;
      idx_q      <= 4'd4;
      hp_q       <= 28'd50000000;
      stb_q      <= 1'b0;
    end else begin
      key_prev_q <= deb_q[3:0];
      press_q    <= press_d;
      man_q      <= man_d;
      pause_q    <= pause_d;
      stb_q      <= (eff_s != idx_q);
      if (eff_s != idx_q) begin
        idx_q <= eff_s;
        hp_q  <= rate_lookup(eff_s);
      end else begin
        idx_q <= idx_q;
        hp_q  <= hp_q;
      end
    end
  end

  assign HALF_PERIOD = hp_q;
  assign RATE_IDX    = idx_q;
  assign RATE_STB    = stb_q;
  assign PAUSE       = pause_q;
  assign KEY_PRESS   = press_q;

endmodule

// File: tb/tb_rate_select.sv
// -----------------------------------------------------------------------------
// tb_rate_select
//   Directed bench for rate_select with a short debounce (N=4, S=2). A
//   behavioural model tracks expected outputs from the input history and is
//   compared against the design every cycle; literal expectations pin the
//   key timing points and final values of each scenario.
// -----------------------------------------------------------------------------
module tb_rate_select;

  localparam int N = 4;
  localparam int S = 2;
  localparam logic [13:0] RST_IN = 14'h000F;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [27:0] HALF_PERIOD;
  logic [3:0]  RATE_IDX;
  logic        RATE_STB;
  logic        PAUSE;
  logic [3:0]  KEY_PRESS;

  rate_select #(.DEBOUNCE_CYCLES(N), .SYNC_STAGES(S)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .KEY         (KEY),
    .SW          (SW),
    .HALF_PERIOD (HALF_PERIOD),
    .RATE_IDX    (RATE_IDX),
    .RATE_STB    (RATE_STB),
    .PAUSE       (PAUSE),
    .KEY_PRESS   (KEY_PRESS)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned rate_tab [10] = '{200000000, 150000000, 100000000, 75000000,
                                 50000000, 37500000, 25000000, 12500000,
                                 6250000, 3125000};

  // Model state: raw samples still in flight, debounced levels, run lengths
  logic [13:0] m_q[$];
  logic [13:0] m_deb;
  int          m_run [14];
  logic [3:0]  m_prev_key;
  logic [3:0]  m_press;
  int          m_man;
  int          m_idx;
  logic        m_pause;
  logic        m_stb;
  bit          m_valid = 1'b0;

  int stb_cnt = 0;
  int kp_cnt [4] = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [13:0] syn;
    logic [3:0]  n_press;
    int          eff;
    int          man;
    if (RESET) begin
      m_q.delete();
      for (int s = 0; s < S; s++) m_q.push_back(RST_IN);
      m_deb = RST_IN;
      for (int i = 0; i < 14; i++) m_run[i] = 0;
      m_prev_key = 4'hF;
      m_press    = 4'h0;
      m_man      = 4;
      m_pause    = 1'b0;
      m_idx      = 4;
      m_stb      = 1'b0;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      // what the debounce logic sees now was sampled S edges ago
      syn = m_q.pop_front();
      m_q.push_back({SW, KEY});
      eff = m_man;
      for (int b = 9; b >= 0; b--) begin
        if (m_deb[4+b]) begin
          eff = b;
          break;
        end
      end
      m_stb = (eff != m_idx);
      m_idx = eff;
      man = m_man;
      if (m_press[0]) man = 4;
      else if (m_press[1] && !m_press[2]) man = (man < 9) ? man + 1 : 9;
      else if (m_press[2] && !m_press[1]) man = (man > 0) ? man - 1 : 0;
      m_man   = man;
      m_pause = m_pause ^ m_press[3];
      n_press    = m_prev_key & ~m_deb[3:0];
      m_prev_key = m_deb[3:0];
      m_press    = n_press;
      for (int i = 0; i < 14; i++) begin
        if (syn[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            m_deb[i] = syn[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  // Per-cycle compare against the model, plus pulse counting
  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1;
      model_step();
      if (m_valid) begin
        check("half_period", 32'(HALF_PERIOD), rate_tab[m_idx]);
        check("rate_idx",    32'(RATE_IDX),    32'(m_idx));
        check("rate_stb",    32'(RATE_STB),    32'(m_stb));
        check("pause",       32'(PAUSE),       32'(m_pause));
        check("key_press",   32'(KEY_PRESS),   32'(m_press));
        stb_cnt += int'(RATE_STB);
        for (int k = 0; k < 4; k++) kp_cnt[k] += int'(KEY_PRESS[k]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press(input logic [3:0] mask);
    KEY = ~mask;
    tick(8);
    KEY = 4'hF;
    tick(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k1, k2;
    RESET = 1'b1;
    KEY   = 4'hF;
    SW    = 10'd0;
    tick(3);
    RESET = 1'b0;
    check("rst_idx",   32'(RATE_IDX),    32'd4);
    check("rst_hp",    32'(HALF_PERIOD), 32'd50000000);
    check("rst_stb",   32'(RATE_STB),    32'd0);
    check("rst_pause", 32'(PAUSE),       32'd0);
    check("rst_kp",    32'(KEY_PRESS),   32'd0);
    tick(4);
    check("idle_no_stb", 32'(stb_cnt), 32'd0);

    // SW[6]: outputs change exactly at edge S+N+1 = 7
    s0 = stb_cnt;
    SW = 10'h040;
    repeat (6) @(posedge CLOCK_50);
    #1;
    check("sw6_e6_idx", 32'(RATE_IDX), 32'd4);
    @(posedge CLOCK_50);
    #1;
    check("sw6_e7_idx", 32'(RATE_IDX),    32'd6);
    check("sw6_e7_hp",  32'(HALF_PERIOD), 32'd25000000);
    check("sw6_e7_stb", 32'(RATE_STB),    32'd1);
    @(posedge CLOCK_50);
    #1;
    check("sw6_e8_stb", 32'(RATE_STB), 32'd0);
    tick(6);
    SW = 10'd0;
    tick(10);
    check("sw6_back_idx", 32'(RATE_IDX), 32'd4);
    check("sw6_stb_cnt",  32'(stb_cnt - s0), 32'd2);

    // SW[2]+SW[8], then SW[8] cleared
    s0 = stb_cnt;
    SW = 10'h104;
    tick(10);
    check("sw28_idx", 32'(RATE_IDX),    32'd8);
    check("sw28_hp",  32'(HALF_PERIOD), 32'd6250000);
    SW = 10'h004;
    tick(10);
    check("sw2_idx", 32'(RATE_IDX),    32'd2);
    check("sw2_hp",  32'(HALF_PERIOD), 32'd100000000);
    check("sw28_stb_cnt", 32'(stb_cnt - s0), 32'd2);
    SW = 10'd0;
    tick(10);
    check("sw_off_idx", 32'(RATE_IDX), 32'd4);

    // KEY[1] x6 with latency check on the first press
    s0 = stb_cnt;
    k1 = kp_cnt[1];
    KEY = 4'hD;
    repeat (7) @(posedge CLOCK_50);
    #1;
    check("k1_e7_kp", 32'(KEY_PRESS), 32'd2);
    @(posedge CLOCK_50);
    #1;
    check("k1_e8_kp",  32'(KEY_PRESS), 32'd0);
    check("k1_e8_idx", 32'(RATE_IDX),  32'd4);
    @(posedge CLOCK_50);
    #1;
    check("k1_e9_idx", 32'(RATE_IDX), 32'd5);
    check("k1_e9_stb", 32'(RATE_STB), 32'd1);
    tick(5);
    KEY = 4'hF;
    tick(8);
    for (int p = 0; p < 5; p++) press(4'b0010);
    check("k1x6_idx", 32'(RATE_IDX),    32'd9);
    check("k1x6_hp",  32'(HALF_PERIOD), 32'd3125000);
    check("k1x6_stb_cnt", 32'(stb_cnt - s0), 32'd5);
    check("k1x6_kp_cnt",  32'(kp_cnt[1] - k1), 32'd6);
    press(4'b0001);
    check("k0_idx", 32'(RATE_IDX), 32'd4);

    // KEY[2] glitch of 3 cycles
    s0 = stb_cnt;
    k2 = kp_cnt[2];
    KEY = 4'hB;
    tick(3);
    KEY = 4'hF;
    tick(10);
    check("glitch_kp",  32'(kp_cnt[2] - k2), 32'd0);
    check("glitch_stb", 32'(stb_cnt - s0),   32'd0);
    check("glitch_idx", 32'(RATE_IDX),       32'd4);

    // Manual index keeps moving in switch mode
    SW = 10'h002;
    tick(10);
    check("swmode_idx", 32'(RATE_IDX), 32'd1);
    press(4'b0010);
    press(4'b0010);
    check("swmode_hold_idx", 32'(RATE_IDX), 32'd1);
    SW = 10'd0;
    tick(10);
    check("man_resume_idx", 32'(RATE_IDX), 32'd6);
    press(4'b0001);

    // KEY[1]+KEY[2] together, then KEY[3] twice
    s0 = stb_cnt;
    k1 = kp_cnt[1];
    k2 = kp_cnt[2];
    press(4'b0110);
    check("k12_idx", 32'(RATE_IDX), 32'd4);
    check("k12_stb", 32'(stb_cnt - s0), 32'd0);
    check("k12_kp1", 32'(kp_cnt[1] - k1), 32'd1);
    check("k12_kp2", 32'(kp_cnt[2] - k2), 32'd1);
    press(4'b1000);
    check("pause_on", 32'(PAUSE), 32'd1);
    press(4'b1000);
    check("pause_off", 32'(PAUSE), 32'd0);
    check("pause_no_stb", 32'(stb_cnt - s0), 32'd0);

    // Reset in the middle of a SW[9] debounce
    SW = 10'h200;
    tick(3);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    repeat (6) @(posedge CLOCK_50);
    #1;
    check("rst_abort_idx", 32'(RATE_IDX), 32'd4);
    check("rst_abort_stb", 32'(RATE_STB), 32'd0);
    @(posedge CLOCK_50);
    #1;
    check("rst_redo_idx", 32'(RATE_IDX), 32'd9);
    check("rst_redo_stb", 32'(RATE_STB), 32'd1);
    tick(2);
    SW = 10'd0;
    tick(10);
    check("final_idx", 32'(RATE_IDX), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
